// File: rtl/uart_word_pkg.sv
// Shared constants and FSM encoding for the word-to-UART serializer.
// Optional feature macro: UART_WORD_CHECKSUM_EN (adds the CSUM state).
package uart_word_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic        UART_START_BIT = 1'b0;
  localparam logic        UART_STOP_BIT  = 1'b1;
  // Idle-high cycles between a stop bit and the next start bit (LOAD, SEND, sub-module latch).
  localparam int unsigned IFG_CYCLES     = 3;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StSend = 3'd2,
    StWait = 3'd3,
`ifdef UART_WORD_CHECKSUM_EN
    StCsum = 3'd4,
`endif
    StDone = 3'd5
  } state_e;

  // Byte-index width; never narrower than one bit, even for a single-byte word.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// Handshake bundle between the result register side and the word serializer.
interface uart_word_tx_if #(
  parameter int unsigned WORD_W = 256
);
  logic              start;
  logic [WORD_W-1:0] data_in;
  logic              msb_first;
  logic              busy;
  logic              done;
  logic              tx;

  modport master (output start, data_in, msb_first, input busy, done, tx);
  modport slave  (input start, data_in, msb_first, output busy, done, tx);
endinterface

// File: rtl/uart_tx_byte.sv
// Single 8N1 UART frame transmitter; owns the baud and bit counters.
// byte_done is high during the last cycle of the stop bit.
module uart_tx_byte
  import uart_word_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_byte_valid,
  input  logic [7:0] i_byte_data,
  output logic       o_tx,
  output logic       o_byte_active,
  output logic       o_byte_done
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] DONE_BAUD = BAUD_W'(CLKS_PER_BIT - 2);
  // Bit slot 0 is the start bit, 1..8 data, 9 the stop bit.
  localparam logic [3:0] STOP_SLOT = 4'(UART_DATA_BITS + 1);
  localparam logic [3:0] LAST_DATA = 4'(UART_DATA_BITS);

  logic              r_tx;
  logic              r_active;
  logic              r_done;
  logic [BAUD_W-1:0] r_baud;
  logic [3:0]        r_bit;
  logic [7:0]        r_shift;

  // Frame sequencer: latch a byte when idle, then shift it out one bit per baud period.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx     <= UART_STOP_BIT;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
    end else begin
      r_done <= 1'b0;
      if (!r_active) begin
        if (i_byte_valid) begin
          r_tx     <= UART_START_BIT;
          r_active <= 1'b1;
          r_baud   <= '0;
          r_bit    <= '0;
          r_shift  <= i_byte_data;
        end
      end else if (r_baud == LAST_BAUD) begin
        r_baud <= '0;
        if (r_bit == STOP_SLOT) begin
          r_active <= 1'b0;
          r_tx     <= UART_STOP_BIT;
        end else begin
          r_bit <= r_bit + 4'd1;
          if (r_bit == LAST_DATA) begin
            r_tx <= UART_STOP_BIT;
          end else begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
        end
      end else begin
        r_baud <= r_baud + 1'b1;
        if (r_bit == STOP_SLOT && r_baud == DONE_BAUD) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_tx          = r_tx;
  assign o_byte_active = r_active;
  assign o_byte_done   = r_done;

endmodule

// File: rtl/uart_word_tx.sv
// Word-to-UART serializer: latches a WORD_W-bit word on start and sends it as WORD_W/8
// 8N1 frames in LSB-first or MSB-first byte order, then pulses done.
// Optional feature macro: UART_WORD_CHECKSUM_EN appends an XOR checksum frame.
module uart_word_tx
  import uart_word_pkg::*;
#(
  parameter int unsigned WORD_W       = 256,
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input logic           clock,
  input logic           reset,
  uart_word_tx_if.slave bus
);

  localparam int unsigned N_BYTES = WORD_W / 8;
  localparam int unsigned CNT_W   = cnt_width(N_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);

  state_e            r_state;
  logic [WORD_W-1:0] r_word;
  logic              r_msb_first;
  logic [CNT_W-1:0]  r_idx;
  logic [7:0]        r_byte;
  logic              r_byte_valid;
  logic              r_busy;
  logic              r_done;
`ifdef UART_WORD_CHECKSUM_EN
  logic [7:0]        r_csum;
  logic              r_csum_sent;
`endif

  logic [CNT_W-1:0]  w_sel_idx;
  logic [7:0]        w_byte;
  logic              w_tx;
  logic              w_byte_active;
  logic              w_byte_done;

  assign w_sel_idx = r_msb_first ? (LAST_IDX - r_idx) : r_idx;

  // Byte mux: pick the frame payload out of the shadow word.
  always_comb begin
    w_byte = '0;
    for (int b = 0; b < N_BYTES; b++) begin
      if (w_sel_idx == CNT_W'(b)) begin
        w_byte = r_word[b*8 +: 8];
      end
    end
  end

  // Transfer sequencer with registered busy/done/byte_valid outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= StIdle;
      r_word       <= '0;
      r_msb_first  <= 1'b0;
      r_idx        <= '0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef UART_WORD_CHECKSUM_EN
      r_csum       <= '0;
      r_csum_sent  <= 1'b0;
`endif
    end else begin
      r_done       <= 1'b0;
      r_byte_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_word      <= bus.data_in;
            r_msb_first <= bus.msb_first;
            r_idx       <= '0;
            r_busy      <= 1'b1;
            r_state     <= StLoad;
`ifdef UART_WORD_CHECKSUM_EN
            r_csum      <= '0;
            r_csum_sent <= 1'b0;
`endif
          end
        end
        StLoad: begin
          r_byte  <= w_byte;
`ifdef UART_WORD_CHECKSUM_EN
          r_csum  <= r_csum ^ w_byte;
`endif
          r_state <= StSend;
        end
        StSend: begin
          // The previous frame has always finished by now; the check keeps a stray
          // byte_valid from being dropped silently if the gap is ever shortened.
          if (!w_byte_active) begin
            r_byte_valid <= 1'b1;
            r_state      <= StWait;
          end
        end
        StWait: begin
          if (w_byte_done) begin
            if (r_idx != LAST_IDX) begin
              r_idx   <= r_idx + 1'b1;
              r_state <= StLoad;
            end
`ifdef UART_WORD_CHECKSUM_EN
            else if (!r_csum_sent) begin
              r_csum_sent <= 1'b1;
              r_state     <= StCsum;
            end
`endif
            else begin
              r_state <= StDone;
            end
          end
        end
`ifdef UART_WORD_CHECKSUM_EN
        StCsum: begin
          r_byte  <= r_csum;
          r_state <= StSend;
        end
`endif
        StDone: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_byte (
    .clock         (clock),
    .reset         (reset),
    .i_byte_valid  (r_byte_valid),
    .i_byte_data   (r_byte),
    .o_tx          (w_tx),
    .o_byte_active (w_byte_active),
    .o_byte_done   (w_byte_done)
  );

  assign bus.tx   = w_tx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: a per-cycle timeline model of tx/busy/done, a UART decoder for
// directed words, and a randomized phase with mid-transfer pokes, held start and resets.
module tb_uart_word_tx;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CPB    = 4;
  localparam int unsigned NB     = WORD_W / 8;
`ifdef UART_WORD_CHECKSUM_EN
  localparam int unsigned NF     = NB + 1;
  localparam int unsigned T1_CYC = 130;
`else
  localparam int unsigned NF     = NB;
  localparam int unsigned T1_CYC = 87;
`endif
  localparam int unsigned FRAME  = 10 * CPB + 3;
  localparam int unsigned TOTAL  = NF * FRAME + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  uart_word_tx_if #(.WORD_W(WORD_W)) bus ();

  uart_word_tx #(
    .WORD_W       (WORD_W),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  bit         m_active = 1'b0;
  int         m_k      = 0;
  logic [7:0] m_bytes [NF];
  logic       m_etx, m_ebusy, m_edone;

  // Line level k edges after the accepting edge: 3 idle cycles, then frames every FRAME cycles.
  function automatic logic model_tx(input int k);
    int f, p, b;
    if (k < 3) return 1'b1;
    f = (k - 3) / FRAME;
    p = (k - 3) % FRAME;
    if (f >= NF || p >= 10 * CPB) return 1'b1;
    b = p / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_bytes[f][b-1];
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_active = 1'b0;
      m_etx = 1'b1; m_ebusy = 1'b0; m_edone = 1'b0;
    end else if (m_active) begin
      m_k++;
      m_etx   = model_tx(m_k);
      m_ebusy = (m_k < TOTAL);
      m_edone = (m_k == TOTAL);
      if (m_k == TOTAL) m_active = 1'b0;
    end else if (bus.start) begin
      for (int i = 0; i < NB; i++) begin
        int s;
        s = bus.msb_first ? (NB - 1 - i) : i;
        m_bytes[i] = bus.data_in[8*s +: 8];
      end
`ifdef UART_WORD_CHECKSUM_EN
      m_bytes[NB] = 8'h00;
      for (int i = 0; i < NB; i++) m_bytes[NB] = m_bytes[NB] ^ m_bytes[i];
`endif
      m_active = 1'b1;
      m_k = 0;
      m_etx = 1'b1; m_ebusy = 1'b1; m_edone = 1'b0;
    end else begin
      m_etx = 1'b1; m_ebusy = 1'b0; m_edone = 1'b0;
    end
    #1;
    check("tx", 32'(bus.tx), 32'(m_etx));
    check("busy", 32'(bus.busy), 32'(m_ebusy));
    check("done", 32'(bus.done), 32'(m_edone));
    if (bus.done === 1'b1) n_done++;
  end

  // ---------------- directed helpers ----------------
  logic       trace [0:4095];
  logic [7:0] mon_q [$];

  task automatic launch(input logic [WORD_W-1:0] d, input logic m);
    @(negedge clock);
    bus.data_in = d; bus.msb_first = m; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  // Counts edges from the accepting edge to done, recording tx; optionally re-pulses start
  // with a different word at edge poke_at.
  task automatic wait_done(input int poke_at, output int cyc);
    cyc = 0;
    trace[0] = 1'b1;
    while (cyc < 4000) begin
      @(posedge clock); #1;
      cyc++;
      trace[cyc] = bus.tx;
      if (cyc == poke_at) begin
        bus.start = 1'b1;
        bus.data_in = ~bus.data_in;
        bus.msb_first = ~bus.msb_first;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) break;
    end
    check("done_within_budget", 32'(bus.done), 32'd1);
  endtask

  // Plain UART receiver over the recorded trace: mid-bit sampling after each falling edge.
  task automatic decode(input int len);
    int i;
    i = 1;
    mon_q.delete();
    while (i + 10 * CPB <= len) begin
      if (trace[i] == 1'b0 && trace[i-1] == 1'b1) begin
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = trace[i + CPB/2 + CPB*(j+1)];
        check("stop_bit", 32'(trace[i + CPB/2 + 9*CPB]), 32'd1);
        mon_q.push_back(b);
        i += 10 * CPB;
      end else begin
        i++;
      end
    end
  endtask

  task automatic check_frames(input string name, input logic [7:0] e0, input logic [7:0] e1);
    check({name, "_nframes"}, 32'(mon_q.size()), 32'(NF));
    if (mon_q.size() >= 2) begin
      check({name, "_frame0"}, 32'(mon_q[0]), 32'(e0));
      check({name, "_frame1"}, 32'(mon_q[1]), 32'(e1));
`ifdef UART_WORD_CHECKSUM_EN
      if (mon_q.size() >= 3) check({name, "_csum"}, 32'(mon_q[2]), 32'(e0 ^ e1));
`endif
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, d0;
    bit hold;
    bus.start = 1'b0; bus.data_in = '0; bus.msb_first = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_tx", 32'(bus.tx), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // LSB-first A55A: 5A then A5
    launch(16'hA55A, 1'b0);
    wait_done(0, cyc);
    check("t1_cycles", 32'(cyc), 32'(T1_CYC));
    decode(cyc);
    check_frames("t1", 8'h5A, 8'hA5);

    // MSB-first: A5 then 5A
    repeat (3) @(negedge clock);
    launch(16'hA55A, 1'b1);
    wait_done(0, cyc);
    decode(cyc);
    check_frames("t2", 8'hA5, 8'h5A);

    // start again mid-transfer with a new word: ignored, one done
    repeat (3) @(negedge clock);
    d0 = n_done;
    launch(16'h1234, 1'b0);
    wait_done(20, cyc);
    check("t4_cycles", 32'(cyc), 32'(TOTAL));
    decode(cyc);
    check_frames("t4", 8'h34, 8'h12);
    repeat (FRAME) @(posedge clock);
    check("t4_done_count", 32'(n_done - d0), 32'd1);

    // reset during the second frame's data bits
    @(negedge clock);
    d0 = n_done;
    launch(16'hC396, 1'b0);
    repeat (3 + FRAME + 3 * CPB - 1) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("t5_tx_after_reset", 32'(bus.tx), 32'd1);
    check("t5_busy_after_reset", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    repeat (3 * FRAME) @(posedge clock);
    #1;
    check("t5_no_done", 32'(n_done - d0), 32'd0);
    launch(16'hC396, 1'b0);
    wait_done(0, cyc);
    decode(cyc);
    check_frames("t5", 8'h96, 8'hC3);

    // randomized: sparse or held start, data/order churn, rare resets
    hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (c % 400 == 0) hold = ($urandom_range(0, 1) == 1);
      bus.start = hold ? 1'b1 : ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) bus.data_in = WORD_W'($urandom);
      if ($urandom_range(0, 15) == 0) bus.msb_first = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 999) == 0);
    end
    @(negedge clock);
    reset = 1'b0; bus.start = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
